// File: rtl/sys_arr_feed_ctrl.sv
// Skewed west-edge feed for the systolic array: pops K_LEN words per row FIFO, row r trailing row 0 by r cycles.
// Pop-to-arr_dat latency 1; an empty FIFO on any active row stalls every row in lockstep so the skew never drifts.
module sys_arr_feed_ctrl #(
  parameter int ROWS   = 4,
  parameter int K_LEN  = 16,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ROWS-1:0]          fifo_empty,
  input  logic [ROWS*WORD_W-1:0]   fifo_dat,
  output logic [ROWS-1:0]          fifo_pop,
  output logic [ROWS*WORD_W-1:0]   arr_dat,
  output logic [ROWS-1:0]          arr_vld,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int              T_W      = $clog2(K_LEN + ROWS);
  localparam int              T_LAST_I = K_LEN + ROWS - 2;
  localparam logic [T_W-1:0]  T_LAST   = T_W'(T_LAST_I);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]      state;
  logic [T_W-1:0]  t;
  logic [ROWS-1:0] active;
  logic            stall;
  logic            feeding;
  logic            last_beat;

  // Row r is on the wavefront for t in [r, r+K_LEN-1].
  always_comb begin
    active = '0;
    for (int r = 0; r < ROWS; r++) begin
      active[r] = (int'(t) >= r) && (int'(t) <= r + K_LEN - 1);
    end
  end

  always_comb begin
    stall     = (state == FEED) && |(active & fifo_empty);
    feeding   = nRST && !abort && (state == FEED) && !stall;
    fifo_pop  = feeding ? active : '0;
    last_beat = feeding && (t == T_LAST);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      t         <= '0;
      stall_cnt <= '0;
      arr_vld   <= '0;
      arr_dat   <= '0;
      done      <= 1'b0;
    end else begin
      // fifo_pop is already zero outside a live FEED cycle, so the data path needs no state decode.
      arr_vld <= fifo_pop;
      for (int r = 0; r < ROWS; r++) begin
        arr_dat[r*WORD_W +: WORD_W] <= fifo_pop[r] ? fifo_dat[r*WORD_W +: WORD_W] : '0;
      end
      done <= last_beat;

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= FEED;
              t         <= '0;
              stall_cnt <= '0;
            end
          end
          FEED: begin
            if (stall) begin
              if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end else begin
              t <= t + 1'b1;
              if (last_beat) state <= FLUSH;
            end
          end
          FLUSH:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
